ibex_rf_l2_sched: RTL
=====================

IBEX_RF_L2_SCHED -- requirements
Module: ibex_rf_l2_sched

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter AddrWidth, default 5, meaning the register address width.
REQ-003 The block SHALL use these ports; the clock is clk_i, the reset is rst_i, there is one clock, and reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  new instruction operand lookup
- miss_a_i / miss_b_i  in  1 each  operand A / B not in L1
- raddr_a_i / raddr_b_i  in  AddrWidth each  operand addresses
- kill_i  in  1  abandon outstanding read
- wr_req_i  in  1  L2 write request
- wr_ready_o  out  1  write accepted this cycle
- waddr_i  in  AddrWidth  write address
- wdata_i  in  DataWidth  write data
- l2_addr_o  out  AddrWidth  L2 port address
- l2_re_o / l2_we_o  out  1 each  L2 read / write strobe
- l2_wdata_o  out  DataWidth  L2 write data
- l2_rdata_i  in  DataWidth  L2 read data, combinational from l2_addr_o
- rdata_a_o / rdata_b_o  out  DataWidth each  fetched operands
- valid_a_o / valid_b_o  out  1 each  operand valid
- stall_o  out  1  pipeline stall

Function
REQ-004 The FSM SHALL have four states:
- IDLE
- RD_A
- RD_B
- RESP
REQ-005 In IDLE with req_valid_i=1, the next state SHALL be:
- RD_A if miss_a_i=1
- RD_B if only miss_b_i=1
- IDLE if neither is set
REQ-006 The block SHALL latch both addresses on entry.
REQ-007 From RD_A, the next state SHALL be RD_B if the latched miss_b is set, else RESP.
REQ-008 From RD_B, the next state SHALL be RESP.
REQ-009 From RESP, the next state SHALL be IDLE unconditionally.
REQ-010 A miss flag SHALL be ignored when its address is 0: the operand needs no read and rdata for it is 0.
REQ-011 In RD_A/RD_B the block SHALL drive l2_addr_o with the latched address and l2_re_o=1, and SHALL capture l2_rdata_i into the operand buffer at the clock edge ending that cycle.
REQ-012 stall_o SHALL be combinationally 1:
- in IDLE when req_valid_i=1 and any miss is set
- in RD_A and in RD_B
REQ-013 stall_o SHALL be 0 in RESP and otherwise.
REQ-014 Latency SHALL be: single miss → stall for 2 cycles, RESP on the 3rd; dual miss → stall for 3 cycles, RESP on the 4th.
REQ-015 In RESP, valid_a_o/valid_b_o SHALL be 1 for each operand fetched.
REQ-016 Operand buffers SHALL hold their value until the next capture.
REQ-017 valid_* SHALL be 0 in all other states.
REQ-018 The block SHALL hold a 1-entry write buffer with wb_valid, wb_addr and wb_data.
REQ-019 In IDLE and RESP the L2 port SHALL be free for writes:
- if wb_valid, write wb_* to L2 (l2_we_o=1)
- else if wr_req_i, write waddr_i/wdata_i directly
REQ-020 wr_ready_o SHALL be 1 in IDLE and RESP.
REQ-021 In IDLE/RESP with wb_valid=1 and wr_req_i=1, the block SHALL drain the buffer to L2 and load the new write into the buffer.
REQ-022 In RD_A/RD_B, an incoming write SHALL be buffered if wb_valid=0.
REQ-023 In RD_A/RD_B, wr_ready_o SHALL be 1 only if wb_valid=0, and 0 otherwise; the requester holds wr_req_i.
REQ-024 l2_we_o and l2_re_o SHALL never be 1 in the same cycle.
REQ-025 Writes to address 0 SHALL be accepted (wr_ready_o=1) and discarded, with no l2_we_o and no buffering.
REQ-026 Forwarding: in RD_x, if a write accepted in the same cycle matches the read address, the operand SHALL take wdata_i.
REQ-027 Otherwise, if wb_valid and wb_addr match, the operand SHALL take wb_data.
REQ-028 Otherwise the operand SHALL take l2_rdata_i; newest data wins.
REQ-029 kill_i=1 in RD_A/RD_B SHALL make the next state IDLE and drop the captured operands; valid_* SHALL not assert.
REQ-030 kill_i SHALL NOT affect the write buffer, and SHALL have no effect in IDLE/RESP.
REQ-031 req_valid_i outside IDLE SHALL be ignored.

Reset
REQ-032 On rst_i=1 at a clock edge:
- state → IDLE
- wb_valid, valid_a_o, valid_b_o, stall_o, l2_re_o, l2_we_o → 0
- buffers, l2_addr_o, l2_wdata_o, rdata_* → 0
- wr_ready_o → 1
REQ-033 A buffered write SHALL be lost on reset.
REQ-034 Reset SHALL take priority over all inputs, including mid-read.

Verification
REQ-035 Dual miss: req_valid_i with miss_a/miss_b set, raddr_a=5, raddr_b=20, L2[5]=0xA5A5A5A5, L2[20]=0x12345678 → stall_o 1 for cycles 0–2, l2_addr 5 then 20, RESP in cycle 3 with both valid and the correct data.
REQ-036 Single miss on B with raddr_b=0 → no stall, no L2 read, rdata_b_o=0.
REQ-037 Write during RD_A:
- wr_req_i waddr=7 is buffered (wr_ready_o=1)
- a second write in RD_B sees wr_ready_o=0
- both writes reach L2 in order during RESP/IDLE
REQ-038 Forward: buffered write 7=0xDEADBEEF, then a miss on raddr_a=7 → rdata_a_o=0xDEADBEEF with no l2_re_o on address 7.
REQ-039 kill_i in RD_A of a dual miss → IDLE next cycle, stall_o=0, no valid pulse; the pending buffered write is still drained.
REQ-040 rst_i asserted in RD_B with wb_valid=1 → next cycle IDLE, all outputs at reset values, no l2_we_o issued.

Source files
------------

// File: rtl/ibex_rf_l2_sched.sv
// ---------------------------------------------------------------------------
// ibex_rf_l2_sched
// Schedules the single L2 register-file port between operand reads (for
// operands that missed in L1) and writes. Writes that arrive while a read
// owns the port are parked in a one-entry write buffer and drained when the
// port is free again. Operand reads forward from the newest matching write.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i                  new operand lookup (honoured in IDLE only)
//   miss_a_i/miss_b_i            operand not present in L1
//   raddr_a_i/raddr_b_i          operand addresses (address 0 never read)
//   kill_i                       abandon an outstanding read
//   wr_req_i/waddr_i/wdata_i     write request, held until wr_ready_o
//   wr_ready_o                   write accepted this cycle
//   l2_addr_o/l2_re_o/l2_we_o    L2 port address and strobes
//   l2_wdata_o/l2_rdata_i        L2 write data / combinational read data
//   rdata_a_o/rdata_b_o          fetched operands (held until next capture)
//   valid_a_o/valid_b_o          operand valid, only in RESP
//   stall_o                      pipeline stall
// ---------------------------------------------------------------------------
module ibex_rf_l2_sched #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic                 miss_a_i,
  input  logic                 miss_b_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  input  logic [AddrWidth-1:0] raddr_b_i,
  input  logic                 kill_i,
  input  logic                 wr_req_i,
  output logic                 wr_ready_o,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [AddrWidth-1:0] l2_addr_o,
  output logic                 l2_re_o,
  output logic                 l2_we_o,
  output logic [DataWidth-1:0] l2_wdata_o,
  input  logic [DataWidth-1:0] l2_rdata_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 valid_a_o,
  output logic                 valid_b_o,
  output logic                 stall_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD_A = 2'd1;
  localparam logic [1:0] S_RD_B = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]           r_state;
  logic                 r_need_a;
  logic                 r_need_b;
  logic [AddrWidth-1:0] r_addr_a;
  logic [AddrWidth-1:0] r_addr_b;
  logic [DataWidth-1:0] r_rdata_a;
  logic [DataWidth-1:0] r_rdata_b;
  logic                 r_wb_valid;
  logic [AddrWidth-1:0] r_wb_addr;
  logic [DataWidth-1:0] r_wb_data;

  logic                 w_miss_a;
  logic                 w_miss_b;
  logic                 w_in_rd;
  logic                 w_port_free;
  logic                 w_wr_nz;
  logic                 w_wr_ready;
  logic [AddrWidth-1:0] w_rd_addr;
  logic                 w_fwd_new;
  logic                 w_fwd_wb;
  logic [DataWidth-1:0] w_rd_data;

  // A miss on address 0 needs no read: register 0 always reads as zero.
  assign w_miss_a    = miss_a_i && (raddr_a_i != '0);
  assign w_miss_b    = miss_b_i && (raddr_b_i != '0);
  assign w_in_rd     = (r_state == S_RD_A) || (r_state == S_RD_B);
  assign w_port_free = (r_state == S_IDLE) || (r_state == S_RESP);
  // Writes to address 0 are accepted but never reach L2 or the buffer.
  assign w_wr_nz     = wr_req_i && (waddr_i != '0);

  // During a read a write can only be taken if the buffer has room.
  assign w_wr_ready  = w_in_rd ? (!r_wb_valid || (waddr_i == '0)) : 1'b1;
  assign wr_ready_o  = w_wr_ready;

  assign w_rd_addr   = (r_state == S_RD_A) ? r_addr_a : r_addr_b;

  // Newest data wins: a write taken this cycle beats the buffered one, which
  // beats L2. Only one of the two forward sources can match, because a new
  // write is only taken during a read when the buffer is empty.
  assign w_fwd_new   = w_in_rd && w_wr_nz && !r_wb_valid && (waddr_i == w_rd_addr);
  assign w_fwd_wb    = w_in_rd && r_wb_valid && (r_wb_addr == w_rd_addr);
  assign w_rd_data   = w_fwd_new ? wdata_i : (w_fwd_wb ? r_wb_data : l2_rdata_i);

  // L2 port: reads own it in RD_x (skipped when forwarded); otherwise it
  // serves the buffered write first, then a direct write.
  always_comb begin
    l2_addr_o  = '0;
    l2_re_o    = 1'b0;
    l2_we_o    = 1'b0;
    l2_wdata_o = '0;
    if (w_in_rd) begin
      l2_addr_o = w_rd_addr;
      l2_re_o   = !(w_fwd_new || w_fwd_wb);
    end else if (r_wb_valid) begin
      l2_addr_o  = r_wb_addr;
      l2_we_o    = 1'b1;
      l2_wdata_o = r_wb_data;
    end else if (w_wr_nz) begin
      l2_addr_o  = waddr_i;
      l2_we_o    = 1'b1;
      l2_wdata_o = wdata_i;
    end
  end

  assign stall_o   = ((r_state == S_IDLE) && req_valid_i && (w_miss_a || w_miss_b)) || w_in_rd;
  assign valid_a_o = (r_state == S_RESP) && r_need_a;
  assign valid_b_o = (r_state == S_RESP) && r_need_b;
  assign rdata_a_o = r_rdata_a;
  assign rdata_b_o = r_rdata_b;

  // Read sequencer and operand buffers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_need_a  <= 1'b0;
      r_need_b  <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_addr_a <= raddr_a_i;
            r_addr_b <= raddr_b_i;
            r_need_a <= w_miss_a;
            r_need_b <= w_miss_b;
            // A miss on register 0 yields zero without any read.
            if (miss_a_i && (raddr_a_i == '0)) r_rdata_a <= '0;
            if (miss_b_i && (raddr_b_i == '0)) r_rdata_b <= '0;
            if (w_miss_a)      r_state <= S_RD_A;
            else if (w_miss_b) r_state <= S_RD_B;
          end
        end
        S_RD_A: begin
          if (kill_i) begin
            r_need_a <= 1'b0;
            r_need_b <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_rdata_a <= w_rd_data;
            r_state   <= r_need_b ? S_RD_B : S_RESP;
          end
        end
        S_RD_B: begin
          if (kill_i) begin
            r_need_a <= 1'b0;
            r_need_b <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_rdata_b <= w_rd_data;
            r_state   <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-entry write buffer. When the port is free the buffer drains and is
  // refilled by a write arriving in the same cycle; during a read a write is
  // parked only if the buffer is empty. kill_i does not touch the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_port_free) begin
      if (r_wb_valid) begin
        r_wb_valid <= w_wr_nz;
        if (w_wr_nz) begin
          r_wb_addr <= waddr_i;
          r_wb_data <= wdata_i;
        end
      end
    end else if (!r_wb_valid && w_wr_nz) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= waddr_i;
      r_wb_data  <= wdata_i;
    end
  end

endmodule
